// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - RV32I multi-cycle fetch/decode controller with PC ownership
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req/addr/valid/rdata    instruction fetch handshake (addr = current pc)
//   instType..imm, pc            registered control word for the datapath
//   ex_valid/ex_done             execute handshake; br_taken/jalr_tgt sampled with ex_done
//   halted, fault, instret       status: stop flag, stop cause, retired-instruction count
module fetch_decode_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [7:0]  FETCH_TMO = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [3:0]  instType,
   output logic [2:0]  fun3,
   output logic        fun7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] pc,
   output logic [31:0] imm,
   output logic        ex_valid,
   input  logic        ex_done,
   input  logic        br_taken,
   input  logic [31:0] jalr_tgt,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_t;

   localparam logic [3:0] T_LOAD  = 4'd0, T_IMM  = 4'd1, T_STORE = 4'd2, T_REG = 4'd3,
                          T_LUI   = 4'd4, T_AUIPC = 4'd5, T_BRNCH = 4'd6, T_JALR = 4'd7,
                          T_JAL   = 4'd8, T_NONE = 4'd15;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [3:0]  type_q, type_d;
   logic [2:0]  fun3_q, fun3_d;
   logic        fun7_q, fun7_d;
   logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [31:0] cwpc_q, cwpc_d, imm_q, imm_d;
   logic        br_q, br_d;
   logic [31:0] tgt_q, tgt_d;
   logic [1:0]  fault_q, fault_d;
   logic [31:0] instret_q, instret_d;

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  dec_type;
   logic [31:0] dec_imm;
   logic        dec_legal, dec_sys;
   logic [31:0] next_pc;
   logic [7:0]  tmo_inc;

   assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u = {ir_q[31:12], 12'b0};
   assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign tmo_inc = tmo_q + 8'd1;

   always_comb begin
      dec_type  = T_NONE;
      dec_imm   = 32'd0;
      dec_legal = 1'b1;
      dec_sys   = 1'b0;
      case (ir_q[6:0])
         7'b0000011: begin dec_type = T_LOAD;  dec_imm = imm_i; end
         7'b0010011: begin dec_type = T_IMM;   dec_imm = imm_i; end
         7'b0100011: begin dec_type = T_STORE; dec_imm = imm_s; end
         7'b0110011: begin dec_type = T_REG;   dec_imm = 32'd0; end
         7'b0110111: begin dec_type = T_LUI;   dec_imm = imm_u; end
         7'b0010111: begin dec_type = T_AUIPC; dec_imm = imm_u; end
         7'b1100011: begin dec_type = T_BRNCH; dec_imm = imm_b; end
         7'b1100111: begin dec_type = T_JALR;  dec_imm = imm_i; end
         7'b1101111: begin dec_type = T_JAL;   dec_imm = imm_j; end
         7'b1110011: begin dec_legal = 1'b0; dec_sys = 1'b1; end
         default:    dec_legal = 1'b0;
      endcase
   end

   // pc_q equals the control-word pc while an instruction is in flight.
   always_comb begin
      next_pc = pc_q + 32'd4;
      case (type_q)
         T_JAL:   next_pc = cwpc_q + imm_q;
         T_BRNCH: if (br_q) next_pc = cwpc_q + imm_q;
         T_JALR:  next_pc = tgt_q & ~32'd1;
         default: next_pc = pc_q + 32'd4;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      tmo_d     = tmo_q;
      type_d    = type_q;
      fun3_d    = fun3_q;
      fun7_d    = fun7_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      cwpc_d    = cwpc_q;
      imm_d     = imm_q;
      br_d      = br_q;
      tgt_d     = tgt_q;
      fault_d   = fault_q;
      instret_d = instret_q;
      case (state_q)
         S_FETCH: begin
            // a response on the last allowed cycle still wins over the timeout
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end else if (tmo_inc == FETCH_TMO) begin
               fault_d = 2'd2;
               state_d = S_HALT;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         S_DECODE: begin
            if (dec_legal) begin
               type_d  = dec_type;
               fun3_d  = ir_q[14:12];
               fun7_d  = ir_q[30];
               rd_d    = ir_q[11:7];
               rs1_d   = ir_q[19:15];
               rs2_d   = ir_q[24:20];
               cwpc_d  = pc_q;
               imm_d   = dec_imm;
               state_d = S_EXEC;
            end else begin
               fault_d = dec_sys ? 2'd0 : 2'd1;
               state_d = S_HALT;
            end
         end
         S_EXEC: begin
            if (ex_done) begin
               br_d    = br_taken;
               tgt_d   = jalr_tgt;
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            if (next_pc[1:0] != 2'b00) begin
               fault_d = 2'd3;
               state_d = S_HALT;
            end else begin
               pc_d      = next_pc;
               instret_d = instret_q + 32'd1;
               tmo_d     = 8'd0;
               state_d   = S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         tmo_q     <= 8'd0;
         type_q    <= T_NONE;
         fun3_q    <= 3'd0;
         fun7_q    <= 1'b0;
         rd_q      <= 5'd0;
         rs1_q     <= 5'd0;
         rs2_q     <= 5'd0;
         cwpc_q    <= RESET_PC;
         imm_q     <= 32'd0;
         br_q      <= 1'b0;
         tgt_q     <= 32'd0;
         fault_q   <= 2'd0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         tmo_q     <= tmo_d;
         type_q    <= type_d;
         fun3_q    <= fun3_d;
         fun7_q    <= fun7_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         cwpc_q    <= cwpc_d;
         imm_q     <= imm_d;
         br_q      <= br_d;
         tgt_q     <= tgt_d;
         fault_q   <= fault_d;
         instret_q <= instret_d;
      end
   end

   // gating with rst drops the request the moment reset asserts
   assign imem_req  = (state_q == S_FETCH) && !rst;
   assign imem_addr = pc_q;
   assign ex_valid  = (state_q == S_EXEC);
   assign halted    = (state_q == S_HALT);
   assign instType  = type_q;
   assign fun3      = fun3_q;
   assign fun7      = fun7_q;
   assign rd        = rd_q;
   assign rs1       = rs1_q;
   assign rs2       = rs2_q;
   assign pc        = cwpc_q;
   assign imm       = imm_q;
   assign fault     = fault_q;
   assign instret   = instret_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - directed self-checking bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [3:0]  instType;
   logic [2:0]  fun3;
   logic        fun7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] pc, imm;
   logic        ex_valid, ex_done, br_taken;
   logic [31:0] jalr_tgt;
   logic        halted;
   logic [1:0]  fault;
   logic [31:0] instret;

   fetch_decode_ctrl #(.RESET_PC(RESET_PC), .FETCH_TMO(8'd255)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .instType(instType), .fun3(fun3), .fun7(fun7), .rd(rd), .rs1(rs1), .rs2(rs2),
      .pc(pc), .imm(imm), .ex_valid(ex_valid), .ex_done(ex_done), .br_taken(br_taken),
      .jalr_tgt(jalr_tgt), .halted(halted), .fault(fault), .instret(instret)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // expected outputs for the cycle currently in progress
   logic        e_req, e_valid, e_halted;
   logic [31:0] e_addr, e_instret, e_pc, e_imm;
   logic [1:0]  e_fault;
   logic [3:0]  e_type;
   logic [2:0]  e_f3;
   logic        e_f7;
   logic [4:0]  e_rd, e_rs1, e_rs2;
   logic [31:0] m_pc;

   function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("imem_req", 32'(imem_req), 32'(e_req));
         cmp("imem_addr", imem_addr, e_addr);
         cmp("ex_valid", 32'(ex_valid), 32'(e_valid));
         cmp("halted", 32'(halted), 32'(e_halted));
         cmp("fault", 32'(fault), 32'(e_fault));
         cmp("instret", instret, e_instret);
         cmp("instType", 32'(instType), 32'(e_type));
         cmp("fun3", 32'(fun3), 32'(e_f3));
         cmp("fun7", 32'(fun7), 32'(e_f7));
         cmp("rd", 32'(rd), 32'(e_rd));
         cmp("rs1", 32'(rs1), 32'(e_rs1));
         cmp("rs2", 32'(rs2), 32'(e_rs2));
         cmp("pc", pc, e_pc);
         cmp("imm", imm, e_imm);
      end
   end

   // kind: 0 executable, 1 system (clean stop), 2 illegal
   function automatic void mdec(input logic [31:0] i, output int kind, output logic [3:0] t,
                                output logic [31:0] im);
      logic [31:0] iimm, simm, bimm, uimm, jimm;
      iimm = 32'($signed(i) >>> 20);
      simm = (iimm & 32'hFFFF_FFE0) | ((i >> 7) & 32'h1F);
      bimm = (simm & ~32'h0000_0801) | ((simm & 32'h1) << 11);
      uimm = i & 32'hFFFF_F000;
      jimm = (32'($signed(i) >>> 11) & 32'hFFF0_0000) | (i & 32'h000F_F000)
           | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
      kind = 0; t = 4'd15; im = 32'd0;
      case (i[6:0])
         7'h03: begin t = 4'd0; im = iimm; end
         7'h13: begin t = 4'd1; im = iimm; end
         7'h23: begin t = 4'd2; im = simm; end
         7'h33: begin t = 4'd3; im = 32'd0; end
         7'h37: begin t = 4'd4; im = uimm; end
         7'h17: begin t = 4'd5; im = uimm; end
         7'h63: begin t = 4'd6; im = bimm; end
         7'h67: begin t = 4'd7; im = iimm; end
         7'h6F: begin t = 4'd8; im = jimm; end
         7'h73: kind = 1;
         default: kind = 2;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_exp();
      e_req = 1'b0; e_addr = RESET_PC; e_valid = 1'b0; e_halted = 1'b0; e_fault = 2'd0;
      e_instret = 32'd0; e_type = 4'd15; e_f3 = 3'd0; e_f7 = 1'b0; e_rd = 5'd0;
      e_rs1 = 5'd0; e_rs2 = 5'd0; e_pc = RESET_PC; e_imm = 32'd0; m_pc = RESET_PC;
   endtask

   task automatic hold_halt(input int n);
      for (int k = 0; k < n; k++) begin
         e_req = 1'b0; e_valid = 1'b0; e_halted = 1'b1;
         imem_valid = 1'b1; imem_rdata = 32'h0050_0093; ex_done = 1'b1;
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_reset_exp();
      #1;
      cmp("rst_req", 32'(imem_req), 32'd0);
      cmp("rst_exvalid", 32'(ex_valid), 32'd0);
      cmp("rst_instret", instret, 32'd0);
      cmp("rst_type", 32'(instType), 32'd15);
      cmp("rst_halted", 32'(halted), 32'd0);
      imem_valid = 1'b0; ex_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      e_req = 1'b1;
   endtask

   task automatic do_instr(input logic [31:0] instr, input int fdelay, input int edelay,
                           input logic br, input logic [31:0] tgt);
      int kind;
      logic [3:0] t;
      logic [31:0] im, target;
      mdec(instr, kind, t, im);
      for (int k = 0; k <= fdelay; k++) begin
         e_req = 1'b1; e_addr = m_pc; e_valid = 1'b0; e_halted = 1'b0;
         imem_valid = (k == fdelay);
         imem_rdata = (k == fdelay) ? instr : 32'hDEAD_BEEF;
         ex_done = 1'b1;
         tick();
      end
      e_req = 1'b0; imem_valid = 1'b0; ex_done = 1'b1;
      tick();
      if (kind != 0) begin
         e_fault = (kind == 1) ? 2'd0 : 2'd1;
         hold_halt(3);
         return;
      end
      e_type = t; e_imm = im; e_f3 = instr[14:12]; e_f7 = instr[30];
      e_rd = instr[11:7]; e_rs1 = instr[19:15]; e_rs2 = instr[24:20]; e_pc = m_pc;
      e_valid = 1'b1;
      for (int k = 0; k <= edelay; k++) begin
         ex_done  = (k == edelay);
         br_taken = (k == edelay) ? br : ~br;
         jalr_tgt = (k == edelay) ? tgt : ~tgt;
         tick();
      end
      e_valid = 1'b0; ex_done = 1'b0; br_taken = ~br; jalr_tgt = 32'h0;
      tick();
      case (t)
         4'd8:    target = m_pc + im;
         4'd6:    target = br ? m_pc + im : m_pc + 32'd4;
         4'd7:    target = {tgt[31:1], 1'b0};
         default: target = m_pc + 32'd4;
      endcase
      if (target[1:0] != 2'b00) begin
         e_fault = 2'd3;
         hold_halt(3);
      end else begin
         m_pc = target;
         e_instret = e_instret + 32'd1;
         e_req = 1'b1; e_addr = m_pc; imem_valid = 1'b0;
      end
   endtask

   localparam logic [31:0] ADDI  = 32'h0050_0093;
   localparam logic [31:0] BEQ   = 32'hFE20_8CE3;
   localparam logic [31:0] JALR  = 32'h0002_80E7;

   int t0;

   initial begin
      rst = 1'b1; imem_valid = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
      br_taken = 1'b0; jalr_tgt = 32'd0;
      set_reset_exp();
      #3;
      cmp("init_req", 32'(imem_req), 32'd0);
      cmp("init_type", 32'(instType), 32'd15);
      cmp("init_addr", imem_addr, RESET_PC);
      cmp("init_instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; e_req = 1'b1; chk_en = 1'b1;

      t0 = cyc;
      do_instr(ADDI, 0, 0, 1'b0, 32'd0);
      cmp("t1_latency", 32'(cyc - t0), 32'd4);
      cmp("t1_addr", imem_addr, 32'h4);
      cmp("t1_type", 32'(instType), 32'd1);
      cmp("t1_rd", 32'(rd), 32'd1);
      cmp("t1_rs1", 32'(rs1), 32'd0);
      cmp("t1_imm", imm, 32'd5);
      cmp("t1_pc", pc, 32'd0);

      do_instr(32'h00C0_006F, 2, 1, 1'b0, 32'd0);
      cmp("jal12_addr", imem_addr, 32'h10);
      do_instr(BEQ, 0, 3, 1'b1, 32'd0);
      cmp("beq_taken_addr", imem_addr, 32'h08);
      cmp("beq_imm", imm, 32'hFFFF_FFF8);
      cmp("beq_pc", pc, 32'h10);
      do_instr(32'h0080_006F, 1, 0, 1'b0, 32'd0);
      cmp("jal8_addr", imem_addr, 32'h10);
      do_instr(BEQ, 0, 0, 1'b0, 32'd0);
      cmp("beq_nt_addr", imem_addr, 32'h14);
      do_instr(JALR, 254, 0, 1'b0, 32'h101);
      cmp("jalr_addr", imem_addr, 32'h100);

      do_instr(32'h0020_A423, 0, 1, 1'b0, 32'd0);
      cmp("sw_imm", imm, 32'd8);
      do_instr(32'hABCD_E1B7, 1, 0, 1'b0, 32'd0);
      cmp("lui_imm", imm, 32'hABCD_E000);
      do_instr(32'hFFFF_F217, 0, 0, 1'b1, 32'd0);
      do_instr(32'hFFC3_2283, 0, 2, 1'b0, 32'd0);
      cmp("lw_imm", imm, 32'hFFFF_FFFC);
      do_instr(32'h4094_03B3, 0, 0, 1'b1, 32'd0);
      cmp("sub_fun7", 32'(fun7), 32'd1);
      cmp("sub_type", 32'(instType), 32'd3);
      do_instr(JALR, 0, 0, 1'b0, 32'hFFFF_FFFC);
      cmp("top_addr", imem_addr, 32'hFFFF_FFFC);
      do_instr(ADDI, 0, 0, 1'b0, 32'd0);
      cmp("wrap_addr", imem_addr, 32'h0);
      cmp("instret_13", instret, 32'd13);
      do_instr(JALR, 0, 0, 1'b0, 32'h102);
      cmp("misalign_halted", 32'(halted), 32'd1);
      cmp("misalign_fault", 32'(fault), 32'd3);
      cmp("misalign_addr", imem_addr, 32'h0);

      do_reset();
      for (int k = 0; k < 255; k++) begin
         e_req = 1'b1; e_addr = m_pc; imem_valid = 1'b0; ex_done = 1'b1;
         tick();
      end
      e_fault = 2'd2;
      hold_halt(3);
      cmp("tmo_halted", 32'(halted), 32'd1);
      cmp("tmo_fault", 32'(fault), 32'd2);
      cmp("tmo_req", 32'(imem_req), 32'd0);

      do_reset();
      do_instr(32'h0000_007F, 0, 0, 1'b0, 32'd0);
      cmp("illegal_fault", 32'(fault), 32'd1);
      cmp("illegal_halted", 32'(halted), 32'd1);

      do_reset();
      do_instr(32'h0000_0073, 1, 0, 1'b0, 32'd0);
      cmp("ecall_fault", 32'(fault), 32'd0);
      cmp("ecall_halted", 32'(halted), 32'd1);

      do_reset();
      do_instr(ADDI, 0, 0, 1'b0, 32'd0);
      do_instr(ADDI, 0, 0, 1'b0, 32'd0);
      cmp("pre_rst_instret", instret, 32'd2);
      e_req = 1'b1; e_addr = m_pc; imem_valid = 1'b1; imem_rdata = ADDI; ex_done = 1'b0;
      tick();
      e_req = 1'b0; imem_valid = 1'b0;
      tick();
      e_type = 4'd1; e_imm = 32'd5; e_f3 = 3'd0; e_f7 = 1'b0; e_rd = 5'd1;
      e_rs1 = 5'd0; e_rs2 = 5'd5; e_pc = m_pc; e_valid = 1'b1; ex_done = 1'b0;
      tick();
      tick();
      do_reset();
      do_instr(ADDI, 0, 0, 1'b0, 32'd0);
      cmp("post_rst_instret", instret, 32'd1);
      cmp("post_rst_addr", imem_addr, 32'h4);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
